sccb_arbiter: RTL

Shares the single `sccb_master` between two register-write requesters. Requester 0 is the OV7670 power-up configuration sequencer; requester 1 is the runtime tuning writer for exposure, gain and brightness. The block arbitrates round-robin, launches exactly one SCCB write per grant and tracks it to completion. A watchdog recovers the arbiter if the master never finishes a write.

---
 rtl/sccb_arbiter_pkg.sv | 23 ++
 rtl/sccb_arbiter_if.sv | 30 +++
 rtl/sccb_timeout_cnt.sv | 28 ++
 rtl/sccb_arbiter.sv | 125 ++++++++++++
 4 files changed

// File: rtl/sccb_arbiter_pkg.sv
// Shared constants, FSM state type and grant helper for the SCCB arbiter.
package sccb_arbiter_pkg;

  localparam int SCCB_ID_W   = 7;
  localparam int SCCB_ADDR_W = 8;
  localparam int SCCB_DATA_W = 8;

  // OV7670 write slave ID.
  localparam logic [SCCB_ID_W-1:0] OV7670_WR_ID = 7'h21;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_LOW  = 2'd2,
    ST_WAIT_HIGH = 2'd3
  } state_t;

  // Round-robin pick: on a tie the requester that did not win last time goes next.
  function automatic logic pick_winner(input logic r0, input logic r1, input logic last);
    return (r0 && r1) ? ~last : r1;
  endfunction

endpackage

// File: rtl/sccb_arbiter_if.sv
// Arbiter <-> sccb_master write-launch bus.
interface sccb_arbiter_if
  import sccb_arbiter_pkg::*;
  ();

  logic                   sccb_ready;
  logic                   start_tx;
  logic [SCCB_ID_W-1:0]   id;
  logic [SCCB_ADDR_W-1:0] addr;
  logic [SCCB_DATA_W-1:0] data_wr;

  // Arbiter side: launches writes, observes master idle flag.
  modport master (
    input  sccb_ready,
    output start_tx,
    output id,
    output addr,
    output data_wr
  );

  // sccb_master side.
  modport slave (
    output sccb_ready,
    input  start_tx,
    input  id,
    input  addr,
    input  data_wr
  );

endinterface

// File: rtl/sccb_timeout_cnt.sv
// Watchdog counter: cleared on each launch, counts while enabled, flags C_TIMEOUT-1.
module sccb_timeout_cnt #(
  parameter int C_TIMEOUT = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(C_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  assign expired = (cnt_q == LAST);

  // Count in-flight cycles; hold at the terminal value rather than wrap.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sccb_arbiter.sv
// Round-robin arbiter sharing one sccb_master between two register writers,
// with one write per grant and a watchdog on each transaction.
module sccb_arbiter
  import sccb_arbiter_pkg::*;
#(
  parameter int C_TIMEOUT = 2_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0,
  input  logic [SCCB_ID_W-1:0]   req0_id,
  input  logic [SCCB_ADDR_W-1:0] req0_addr,
  input  logic [SCCB_DATA_W-1:0] req0_data,
  output logic                   ack0,
  output logic                   done0,
  input  logic                   req1,
  input  logic [SCCB_ID_W-1:0]   req1_id,
  input  logic [SCCB_ADDR_W-1:0] req1_addr,
  input  logic [SCCB_DATA_W-1:0] req1_data,
  output logic                   ack1,
  output logic                   done1,
  sccb_arbiter_if.master         sccb,
  output logic                   busy,
  output logic                   timeout_err
);

  state_t                 state_q, state_d;
  logic                   last_grant_q;
  logic                   cur_q;
  logic                   winner;
  logic                   go;
  logic                   finish;
  logic                   wd_fire;
  logic                   expired;
  logic [SCCB_ID_W-1:0]   id_q;
  logic [SCCB_ADDR_W-1:0] addr_q;
  logic [SCCB_DATA_W-1:0] data_q;

  assign go     = (state_q == ST_IDLE) && (req0 || req1) && sccb.sccb_ready;
  assign winner = pick_winner(req0, req1, last_grant_q);

  assign busy         = (state_q != ST_IDLE);
  assign sccb.id      = id_q;
  assign sccb.addr    = addr_q;
  assign sccb.data_wr = data_q;

  sccb_timeout_cnt #(
    .C_TIMEOUT (C_TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (go),
    .en      ((state_q == ST_WAIT_LOW) || (state_q == ST_WAIT_HIGH)),
    .expired (expired)
  );

  // Next-state and launch strobes; completion beats the watchdog in WAIT_HIGH.
  always_comb begin
    state_d       = state_q;
    finish        = 1'b0;
    wd_fire       = 1'b0;
    sccb.start_tx = 1'b0;
    ack0          = 1'b0;
    ack1          = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (go) state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        sccb.start_tx = 1'b1;
        ack0          = ~cur_q;
        ack1          = cur_q;
        state_d       = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        if (expired) begin
          wd_fire = 1'b1;
          finish  = 1'b1;
          state_d = ST_IDLE;
        end else if (!sccb.sccb_ready) begin
          state_d = ST_WAIT_HIGH;
        end
      end
      ST_WAIT_HIGH: begin
        if (sccb.sccb_ready) begin
          finish  = 1'b1;
          state_d = ST_IDLE;
        end else if (expired) begin
          wd_fire = 1'b1;
          finish  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, grant history, latched write fields and registered done/error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      cur_q        <= 1'b0;
      id_q         <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      done0        <= 1'b0;
      done1        <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (go) begin
        cur_q  <= winner;
        id_q   <= winner ? req1_id   : req0_id;
        addr_q <= winner ? req1_addr : req0_addr;
        data_q <= winner ? req1_data : req0_data;
      end
      if (state_q == ST_LAUNCH) last_grant_q <= cur_q;
      done0 <= finish && !cur_q;
      done1 <= finish && cur_q;
      if (wd_fire) timeout_err <= 1'b1;
    end
  end

endmodule
